// File: rtl/led_framebuffer.sv
// Double-buffered frame buffer and HUB75 row scan engine.
// The processor reads and writes the back bank. The scan FSM streams one
// bit-plane row of the front bank, covering every panel segment at once.
// A requested swap is applied only at the end of the last row of the
// last bit-plane, so a frame is never shown half old and half new.
module led_framebuffer #(
  parameter int MATRIX_WIDTH  = 64,
  parameter int MATRIX_HEIGHT = 32,
  parameter int NUM_SEGMENTS  = 2,
  parameter int DATA_WIDTH    = 8,
  localparam int SCAN_ROWS = MATRIX_HEIGHT / NUM_SEGMENTS,
  localparam int PIX_W     = 3 * DATA_WIDTH,
  localparam int RW        = $clog2(MATRIX_HEIGHT),
  localparam int CW        = $clog2(MATRIX_WIDTH),
  localparam int SW        = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1,
  localparam int BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RW:0]             proc_row,
  input  logic [CW:0]             proc_col,
  input  logic                    proc_we,
  input  logic                    proc_re,
  input  logic [PIX_W-1:0]        proc_data_i,
  output logic [PIX_W-1:0]        proc_data_o,
  output logic                    proc_rvalid,
  input  logic                    swap_req,
  output logic                    swap_pending,
  output logic                    front_sel,
  input  logic                    scan_start,
  input  logic [SW-1:0]           scan_row,
  input  logic [BW-1:0]           bcm_bit,
  output logic                    busy,
  output logic                    shift_valid,
  output logic [NUM_SEGMENTS-1:0] shift_r,
  output logic [NUM_SEGMENTS-1:0] shift_g,
  output logic [NUM_SEGMENTS-1:0] shift_b,
  output logic                    scan_done
);

  localparam int SEGW  = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam int DEPTH = SCAN_ROWS * MATRIX_WIDTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } scan_state_t;

  // Storage: segment x bank x (local_row*MATRIX_WIDTH + col); not reset.
  logic [PIX_W-1:0] mem [NUM_SEGMENTS][2][DEPTH];

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CW-1:0]    col;
  logic [SW-1:0]    lat_row;
  logic [BW-1:0]    lat_bit;
  logic [CW-1:0]    rd_col;
  logic [AW-1:0]    scan_addr;
  logic             frame_boundary;

  logic             proc_valid;
  logic [SEGW-1:0]  proc_seg;
  logic [SW-1:0]    proc_local;
  logic [AW-1:0]    proc_addr;
  logic             back_bank;

  // Processor address decode: segment and local row, plus the range check.
  assign proc_valid = (proc_row < (RW+1)'(MATRIX_HEIGHT)) &&
                      (proc_col < (CW+1)'(MATRIX_WIDTH));
  assign proc_seg   = SEGW'(proc_row / (RW+1)'(SCAN_ROWS));
  assign proc_local = SW'(proc_row % (RW+1)'(SCAN_ROWS));
  assign proc_addr  = AW'({proc_local, proc_col[CW-1:0]});
  assign back_bank  = ~front_sel;

  // Back-bank write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (proc_we && proc_valid) begin
      mem[proc_seg][back_bank][proc_addr] <= proc_data_i;
    end
  end

  // Back-bank read port. Nonblocking semantics return pre-write data on a
  // same-address read/write collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_rvalid <= 1'b0;
      proc_data_o <= {PIX_W{1'b0}};
    end else begin
      proc_rvalid <= proc_re;
      if (proc_re) begin
        proc_data_o <= proc_valid ? mem[proc_seg][back_bank][proc_addr] : {PIX_W{1'b0}};
      end
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scan FSM next-state logic; a start outside IDLE is ignored.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (scan_start) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: state_next = S_SHIFT;
      S_SHIFT: begin
        if (col == CW'(MATRIX_WIDTH - 1)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Column counter and latched scan parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= {CW{1'b0}};
      lat_row <= {SW{1'b0}};
      lat_bit <= {BW{1'b0}};
    end else begin
      if (state == S_IDLE && scan_start) begin
        lat_row <= scan_row;
        lat_bit <= bcm_bit;
      end
      if (state == S_SHIFT) begin
        col <= col + CW'(1);
      end else begin
        col <= {CW{1'b0}};
      end
    end
  end

  // Read one column ahead: column 0 in FETCH, col+1 while shifting col.
  assign rd_col    = (state == S_SHIFT) ? (col + CW'(1)) : {CW{1'b0}};
  assign scan_addr = AW'({lat_row, rd_col});

  assign busy        = (state != S_IDLE);
  assign shift_valid = (state == S_SHIFT);
  assign scan_done   = (state == S_DONE);

  for (genvar s = 0; s < NUM_SEGMENTS; s++) begin : g_seg
    logic [PIX_W-1:0]      scan_q;
    logic [DATA_WIDTH-1:0] ch_r;
    logic [DATA_WIDTH-1:0] ch_g;
    logic [DATA_WIDTH-1:0] ch_b;

    // Front-bank fetch for this segment, one cycle ahead of presentation.
    always_ff @(posedge clk) begin
      if (state == S_FETCH || state == S_SHIFT) begin
        scan_q <= mem[s][front_sel][scan_addr];
      end
    end

    assign ch_r = scan_q[DATA_WIDTH-1:0];
    assign ch_g = scan_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign ch_b = scan_q[3*DATA_WIDTH-1:2*DATA_WIDTH];

    // Column bits are forced low outside SHIFT so idle/reset output is 0.
    assign shift_r[s] = shift_valid & ch_r[lat_bit];
    assign shift_g[s] = shift_valid & ch_g[lat_bit];
    assign shift_b[s] = shift_valid & ch_b[lat_bit];
  end

  assign frame_boundary = (state == S_DONE) &&
                          (lat_row == SW'(SCAN_ROWS - 1)) &&
                          (lat_bit == BW'(DATA_WIDTH - 1));

  // Swap control: latch requests, apply only at the frame boundary. A
  // request that coincides with an applying boundary stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_boundary && swap_pending) begin
      front_sel    <= ~front_sel;
      swap_pending <= swap_req;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_framebuffer.sv
// Directed self-checking bench for led_framebuffer (default parameters).
module tb_led_framebuffer;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  proc_row;
  logic [6:0]  proc_col;
  logic        proc_we;
  logic        proc_re;
  logic [23:0] proc_data_i;
  logic [23:0] proc_data_o;
  logic        proc_rvalid;
  logic        swap_req;
  logic        swap_pending;
  logic        front_sel;
  logic        scan_start;
  logic [3:0]  scan_row;
  logic [2:0]  bcm_bit;
  logic        busy;
  logic        shift_valid;
  logic [1:0]  shift_r;
  logic [1:0]  shift_g;
  logic [1:0]  shift_b;
  logic        scan_done;

  int checks   = 0;
  int failures = 0;

  led_framebuffer dut (
    .clk(clk), .rst(rst),
    .proc_row(proc_row), .proc_col(proc_col),
    .proc_we(proc_we), .proc_re(proc_re),
    .proc_data_i(proc_data_i), .proc_data_o(proc_data_o),
    .proc_rvalid(proc_rvalid),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
    .scan_start(scan_start), .scan_row(scan_row), .bcm_bit(bcm_bit),
    .busy(busy), .shift_valid(shift_valid),
    .shift_r(shift_r), .shift_g(shift_g), .shift_b(shift_b),
    .scan_done(scan_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] r, input logic [6:0] c, input logic [23:0] d);
    proc_row = r; proc_col = c; proc_data_i = d; proc_we = 1'b1;
    @(negedge clk);
    proc_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] r, input logic [6:0] c,
                    input logic [23:0] exp);
    proc_row = r; proc_col = c; proc_re = 1'b1;
    @(negedge clk);
    proc_re = 1'b0;
    chk({tag, "_rvalid"}, 32'(proc_rvalid), 32'd1);
    chk(tag, 32'(proc_data_o), 32'(exp));
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  // Runs one scan starting in the current cycle t, checks its timing and
  // returns the {b,g,r} bits presented at column cap_col plus the swap
  // state seen during the DONE cycle.
  task automatic run_scan(input logic [3:0] row, input logic [2:0] b, input int cap_col,
                          input bit second_start, input bit swap_at_done,
                          output logic [5:0] cap, output logic dfront, output logic dpend);
    int n_valid = 0;
    int first_valid = 0;
    int done_at = 0;
    int n_done = 0;
    int n_busy = 0;
    cap = 6'd0; dfront = 1'b0; dpend = 1'b0;
    scan_row = row; bcm_bit = b; scan_start = 1'b1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (shift_valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = k;
      end
      if (scan_done) begin
        n_done++;
        done_at = k;
        dfront = front_sel;
        dpend  = swap_pending;
      end
      if (busy) n_busy++;
      if (k == 2 + cap_col) cap = {shift_b, shift_g, shift_r};
      if (k == W + 3) chk("scan_idle_after", 32'(busy), 32'd0);
      scan_start = (second_start && k == 10) ? 1'b1 : 1'b0;
      swap_req   = (swap_at_done && k == W + 2) ? 1'b1 : 1'b0;
    end
    chk("scan_nvalid", 32'(n_valid), 32'(W));
    chk("scan_first_valid", 32'(first_valid), 32'd2);
    chk("scan_done_at", 32'(done_at), 32'(W + 2));
    chk("scan_ndone", 32'(n_done), 32'd1);
    chk("scan_nbusy", 32'(n_busy), 32'(W + 2));
  endtask

  initial begin : stim
    logic [5:0] cap;
    logic       dfront;
    logic       dpend;
    int         n_done_after;
    int         n_busy_after;

    rst = 1'b1; proc_row = 6'd0; proc_col = 7'd0; proc_we = 1'b0; proc_re = 1'b0;
    proc_data_i = 24'd0; swap_req = 1'b0; scan_start = 1'b0; scan_row = 4'd0; bcm_bit = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shift_valid", 32'(shift_valid), 32'd0);
    chk("rst_shift_bits", 32'({shift_b, shift_g, shift_r}), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_rvalid", 32'(proc_rvalid), 32'd0);
    chk("rst_data_o", 32'(proc_data_o), 32'd0);
    chk("rst_pending", 32'(swap_pending), 32'd0);
    chk("rst_front_sel", 32'(front_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill the back bank (bank 1 while front_sel=0), back to back.
    wr(6'd5,  7'd7,  24'hA53CFF);
    wr(6'd20, 7'd63, 24'h800000);
    wr(6'd4,  7'd63, 24'h7F0000);
    wr(6'd8,  7'd0,  24'h123456);
    wr(6'd0,  7'd0,  24'h0000AA);
    wr(6'd3,  7'd3,  24'h111111);
    rd("rd_5_7",   6'd5,  7'd7,  24'hA53CFF);
    rd("rd_20_63", 6'd20, 7'd63, 24'h800000);
    rd("rd_4_63",  6'd4,  7'd63, 24'h7F0000);

    // Same-cycle write and read of one address returns the old word.
    proc_row = 6'd3; proc_col = 7'd3; proc_data_i = 24'h222222;
    proc_we = 1'b1; proc_re = 1'b1;
    @(negedge clk);
    proc_we = 1'b0; proc_re = 1'b0;
    chk("rw_same_old", 32'(proc_data_o), 32'h111111);
    rd("rw_same_new", 6'd3, 7'd3, 24'h222222);

    // Out-of-range accesses.
    wr(6'd40, 7'd0,  24'hFFFFFF);
    wr(6'd0,  7'd64, 24'h555555);
    rd("oor_wr_row", 6'd8,  7'd0,  24'h123456);
    rd("oor_wr_col", 6'd0,  7'd0,  24'h0000AA);
    rd("oor_rd_row", 6'd32, 7'd0,  24'h000000);
    rd("oor_rd_col", 6'd0,  7'd64, 24'h000000);

    // Mid-frame swap request waits for the (15,7) boundary.
    pulse_swap();
    chk("swap_pend_set", 32'(swap_pending), 32'd1);
    chk("swap_front_hold", 32'(front_sel), 32'd0);
    run_scan(4'd15, 3'd6, 0, 1'b0, 1'b0, cap, dfront, dpend);
    chk("swap_nb_front", 32'(front_sel), 32'd0);
    chk("swap_nb_pend", 32'(swap_pending), 32'd1);
    run_scan(4'd15, 3'd7, 0, 1'b0, 1'b0, cap, dfront, dpend);
    chk("swap_done_front", 32'(dfront), 32'd0);
    chk("swap_done_pend", 32'(dpend), 32'd1);
    chk("swap_front_after", 32'(front_sel), 32'd1);
    chk("swap_pend_after", 32'(swap_pending), 32'd0);

    // Row 5, bit 0, column 7 of segment 0; a start at t+10 is ignored.
    run_scan(4'd5, 3'd0, 7, 1'b1, 1'b0, cap, dfront, dpend);
    chk("px57_r0", 32'(cap[0]), 32'd1);
    chk("px57_g0", 32'(cap[2]), 32'd0);
    chk("px57_b0", 32'(cap[4]), 32'd1);

    // Local row 4, bit 7, final column: segment 1 blue set, segment 0 not.
    run_scan(4'd4, 3'd7, 63, 1'b0, 1'b0, cap, dfront, dpend);
    chk("px463_b1", 32'(cap[5]), 32'd1);
    chk("px463_b0", 32'(cap[4]), 32'd0);
    chk("px463_r1", 32'(cap[1]), 32'd0);
    chk("px463_g1", 32'(cap[3]), 32'd0);

    // Back bank is now bank 0.
    wr(6'd5, 7'd7, 24'h010203);
    rd("rd_bank0", 6'd5, 7'd7, 24'h010203);

    // Request coinciding with an applying boundary stays pending.
    pulse_swap();
    run_scan(4'd15, 3'd7, 0, 1'b0, 1'b1, cap, dfront, dpend);
    chk("swap2_front", 32'(front_sel), 32'd0);
    chk("swap2_pend", 32'(swap_pending), 32'd1);
    rd("rd_bank1_again", 6'd5, 7'd7, 24'hA53CFF);
    run_scan(4'd15, 3'd7, 0, 1'b0, 1'b0, cap, dfront, dpend);
    chk("swap3_front", 32'(front_sel), 32'd1);
    chk("swap3_pend", 32'(swap_pending), 32'd0);
    rd("rd_bank0_again", 6'd5, 7'd7, 24'h010203);

    // Reset in the middle of SHIFT.
    scan_row = 4'd3; bcm_bit = 3'd2; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_in_shift", 32'(shift_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_shift_valid", 32'(shift_valid), 32'd0);
    chk("mid_rst_shift_bits", 32'({shift_b, shift_g, shift_r}), 32'd0);
    chk("mid_rst_scan_done", 32'(scan_done), 32'd0);
    chk("mid_rst_rvalid", 32'(proc_rvalid), 32'd0);
    chk("mid_rst_data_o", 32'(proc_data_o), 32'd0);
    chk("mid_rst_front", 32'(front_sel), 32'd0);
    chk("mid_rst_pend", 32'(swap_pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done_after = 0;
    n_busy_after = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (scan_done) n_done_after++;
      if (busy) n_busy_after++;
    end
    chk("mid_no_done", 32'(n_done_after), 32'd0);
    chk("mid_no_busy", 32'(n_busy_after), 32'd0);

    // Fresh scan after reset completes normally.
    run_scan(4'd0, 3'd0, 0, 1'b0, 1'b0, cap, dfront, dpend);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
